// File: rtl/fir_pkg.sv
// Shared types, default coefficient table and saturation helper for the TDM FIR core.
package fir_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StOut} fir_state_e;

  localparam logic [15:0] FIR_DEFAULT_COEF [16] = '{
    16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h3000, 16'h2000, 16'h1000,
    16'h0800, 16'h0400, 16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010
  };

  // Taps beyond the 16-entry table power up as zero.
  function automatic logic [15:0] default_coef(input int unsigned k);
    logic [3:0] idx;
    idx = k[3:0];
    return (k < 16) ? FIR_DEFAULT_COEF[idx] : 16'h0000;
  endfunction

  // Clamp a wide signed value into the range of a dw-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int unsigned     dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/fir_sat_round.sv
// Scales the accumulator from Q(CW-1) back to sample format and saturates.
// Define FIR_ROUND_EN for round-half-up; otherwise the shift floors.
module fir_sat_round import fir_pkg::*; #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 36
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] result
);

  logic signed [63:0] acc_ext;
  logic signed [63:0] biased;
  logic signed [63:0] shifted;

  always_comb begin
    acc_ext = 64'(acc);
`ifdef FIR_ROUND_EN
    biased  = acc_ext + (64'sd1 <<< (CW - 2));
`else
    biased  = acc_ext;
`endif
    shifted = biased >>> (CW - 1);
    result  = DW'(saturate(shifted, DW));
  end

endmodule

// File: rtl/fir_tdm_core.sv
// Multi-channel FIR sharing one MAC across NCH channels, with loadable coefficients.
// Optional FIR_ROUND_EN selects rounding instead of floor in the output scaler.
module fir_tdm_core import fir_pkg::*; #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned NTAPS = 16,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int unsigned TW    = $clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DW-1:0]  in_sample,
  input  logic        [CHW-1:0] in_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [DW-1:0]  out_sample,
  output logic        [CHW-1:0] out_chan,
  input  logic                  coef_we,
  input  logic        [TW-1:0]  coef_addr,
  input  logic signed [CW-1:0]  coef_wdata,
  output logic                  coef_drop
);

  localparam int unsigned AW = DW + CW + $clog2(NTAPS);

  fir_state_e state_q, state_d;

  logic signed [DW-1:0]  hist_q [NCH][NTAPS];
  logic signed [CW-1:0]  coef_q [NTAPS];
  logic        [TW-1:0]  wptr_q [NCH];
  logic        [CHW-1:0] ch_q;
  logic        [TW-1:0]  k_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [DW-1:0]  out_sample_q;
  logic        [CHW-1:0] out_chan_q;
  logic                  coef_drop_q;

  logic                    in_fire;
  logic                    chan_ok;
  logic                    addr_ok;
  logic                    mac_last;
  logic        [TW-1:0]    wptr_cur;
  logic        [TW-1:0]    rd_idx;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_nxt;
  logic signed [DW-1:0]    sat_result;

  assign in_fire  = in_valid && in_ready;
  assign chan_ok  = 32'(in_chan) < NCH;
  assign addr_ok  = 32'(coef_addr) < NTAPS;
  assign mac_last = (k_q == TW'(NTAPS - 1));
  assign wptr_cur = wptr_q[ch_q];

  // Newest sample sits at wptr; tap k reaches back k samples, modulo NTAPS.
  always_comb begin
    if (wptr_cur >= k_q) begin
      rd_idx = wptr_cur - k_q;
    end else begin
      rd_idx = TW'(32'(wptr_cur) + NTAPS - 32'(k_q));
    end
  end

  assign prod    = hist_q[ch_q][rd_idx] * coef_q[k_q];
  assign acc_nxt = acc_q + AW'(prod);

  fir_sat_round #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_sat_round (
    .acc    (acc_nxt),
    .result (sat_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_fire && chan_ok) state_d = StMac;
      StMac:   if (mac_last) state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StOut);
    out_sample = out_sample_q;
    out_chan   = out_chan_q;
    coef_drop  = coef_drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < NTAPS; t++) hist_q[c][t] <= '0;
      end
      for (int t = 0; t < NTAPS; t++) coef_q[t] <= CW'(default_coef(t));
      ch_q         <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_chan_q   <= '0;
      coef_drop_q  <= 1'b0;
    end else begin
      // A write landing on the accepting edge is already visible to the MAC pass.
      if (coef_we) begin
        if (state_q == StIdle && addr_ok) coef_q[coef_addr] <= coef_wdata;
        else coef_drop_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (in_fire && chan_ok) begin
            hist_q[in_chan][wptr_q[in_chan]] <= in_sample;
            ch_q  <= in_chan;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_nxt;
          k_q   <= k_q + 1'b1;
          if (mac_last) begin
            wptr_q[ch_q] <= (wptr_cur == TW'(NTAPS - 1)) ? '0 : wptr_cur + 1'b1;
            out_sample_q <= sat_result;
            out_chan_q   <= ch_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
